// File: rtl/triangle_stream_generator.sv
// Signed triangle-wave AXI4-Stream source used as a synthetic fringe signal.
// Optional additive LFSR noise when TRIANGLE_NOISE_EN is defined.
module triangle_stream_generator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int PERIOD_CNT_WIDTH = 16
) (
  input  logic                        SYS_aclk,
  input  logic                        SYS_reset,
  input  logic                        FC_enable,
  input  logic [AXIS_TDATA_WIDTH-1:0] FC_amplitude,
  input  logic [AXIS_TDATA_WIDTH-1:0] FC_step,
  input  logic [PERIOD_CNT_WIDTH-1:0] FC_period_count,
`ifdef TRIANGLE_NOISE_EN
  input  logic [15:0]                 FC_noise_mask,
`endif
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tlast,
  output logic                        STAT_busy,
  output logic                        STAT_error
);
  localparam int W = AXIS_TDATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN} state_t;

  state_t                      state;
  logic                        en_d;
  logic signed [W-1:0]         a_lat, s_lat, cur;
  logic [PERIOD_CNT_WIDTH-1:0] cnt_lat, periods;
  logic signed [W:0]           a_ext, up_sum, dn_sum;
  logic signed [W-1:0]         up_val, dn_val;
  logic                        xfer, start, start_ok, up_hit, dn_hit, done, stop;

  assign xfer     = M_AXIS_tvalid & M_AXIS_tready;
  assign start    = FC_enable & ~en_d;
  assign start_ok = !FC_amplitude[W-1] && (|FC_amplitude) &&
                    !FC_step[W-1] && (|FC_step) &&
                    ($signed(FC_step) <= $signed(FC_amplitude));

  // One extra bit keeps cur +/- S from wrapping near the rails.
  assign a_ext  = {a_lat[W-1], a_lat};
  assign up_sum = {cur[W-1], cur} + {s_lat[W-1], s_lat};
  assign dn_sum = {cur[W-1], cur} - {s_lat[W-1], s_lat};
  assign up_hit = (up_sum >= a_ext);
  assign dn_hit = (dn_sum <= -a_ext);
  assign up_val = up_hit ? a_lat : up_sum[W-1:0];
  assign dn_val = dn_hit ? -a_lat : dn_sum[W-1:0];

  assign done = M_AXIS_tlast && (cnt_lat != '0) && (periods == cnt_lat);
  assign stop = (state != IDLE) && xfer && (!FC_enable || done);

  assign STAT_busy = (state != IDLE);

  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) begin
      state         <= IDLE;
      en_d          <= 1'b0;
      a_lat         <= '0;
      s_lat         <= '0;
      cur           <= '0;
      cnt_lat       <= '0;
      periods       <= '0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tlast  <= 1'b0;
      STAT_error    <= 1'b0;
    end else begin
      en_d <= FC_enable;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              a_lat         <= FC_amplitude;
              s_lat         <= FC_step;
              cnt_lat       <= FC_period_count;
              periods       <= '0;
              cur           <= -$signed(FC_amplitude);
              M_AXIS_tvalid <= 1'b1;
              M_AXIS_tlast  <= 1'b0;
              STAT_error    <= 1'b0;
              state         <= RUN_UP;
            end else begin
              STAT_error <= 1'b1;
            end
          end
        end
        default: begin
          if (stop) begin
            state         <= IDLE;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tlast  <= 1'b0;
            cur           <= '0;
          end else if (xfer) begin
            if (state == RUN_UP) begin
              cur <= up_val;
              if (up_hit) state <= RUN_DOWN;
            end else if (M_AXIS_tlast) begin
              // -A of the finished period was just accepted; climb again.
              cur          <= up_val;
              M_AXIS_tlast <= 1'b0;
              state        <= RUN_UP;
            end else begin
              cur          <= dn_val;
              M_AXIS_tlast <= dn_hit;
              if (dn_hit) periods <= periods + 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef TRIANGLE_NOISE_EN
  logic [15:0]         lfsr, lfsr_nx, nbits;
  logic signed [W-1:0] noise, nz;
  logic signed [W:0]   noisy;
  logic                load;

  assign lfsr_nx = !xfer ? lfsr : ({1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000));
  assign nbits   = lfsr_nx & FC_noise_mask;
  assign nz      = {{(W-16){nbits[15]}}, nbits};
  assign load    = ((state == IDLE) && start && start_ok) || ((state != IDLE) && xfer && !stop);

  // Noise is registered with each new sample so a stalled beat stays stable.
  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) begin
      lfsr  <= 16'hACE1;
      noise <= '0;
    end else begin
      lfsr <= lfsr_nx;
      if (stop)      noise <= '0;
      else if (load) noise <= nz;
    end
  end

  assign noisy        = {cur[W-1], cur} + {noise[W-1], noise};
  assign M_AXIS_tdata = (noisy[W] != noisy[W-1]) ?
                        (noisy[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) :
                        noisy[W-1:0];
`else
  assign M_AXIS_tdata = cur;
`endif

endmodule
